// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: command encoding, FSM states,
// latency limit and the address fault rule.
package mem_pkg;

  localparam logic CMD_READ    = 1'b0;
  localparam logic CMD_WRITE   = 1'b1;
  localparam int   MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth_words);
    addr_fault = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Data-memory port between a core (master) and the memory responder (slave).
interface mem_responder_if;

  logic        enable;
  logic        cmd;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] write_data;
  logic        ready;
  logic        valid;
  logic [31:0] load_data;
  logic        error;

  modport master (
    output enable, cmd, addr, mask, write_data,
    input  ready, valid, load_data, error
  );

  modport slave (
    input  enable, cmd, addr, mask, write_data,
    output ready, valid, load_data, error
  );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port RAM, 32-bit words with byte write enables.
// The read register holds its value until the next read.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_mask,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mask[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end else if (i_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, answers with
// a single valid pulse LATENCY cycles later, flagging misaligned/out-of-range accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic     clk,
  input  logic     rst,
  mem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_cmd, r_fault, r_rd_ok, r_resp_fault, r_error;
  logic [AW-1:0] r_widx;
  logic [3:0]    r_mask;
  logic [31:0]   r_wdata, r_load_data;

  logic          w_ready, w_accept, w_fault, w_enter_resp;
  logic          w_cur_cmd, w_cur_fault, w_ram_en, w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [3:0]    w_ram_mask;
  logic [31:0]   w_ram_wdata, w_rdata, w_resp_data;

  assign w_ready      = (r_state == IDLE) && !rst;
  assign w_accept     = bus.enable && w_ready;
  assign w_fault      = addr_fault(bus.addr, DEPTH_WORDS);
  assign w_enter_resp = !rst && (w_next == RESP) && (r_state != RESP);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = (LATENCY == 1) ? RESP : WAIT;
        else          w_next = IDLE;
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
        else               w_next = WAIT;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY==1 RESP is entered on the accept edge, so the RAM must see the live bus.
  always_comb begin
    w_cur_cmd   = r_cmd;
    w_cur_fault = r_fault;
    w_ram_addr  = r_widx;
    w_ram_mask  = r_mask;
    w_ram_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_cur_cmd   = bus.cmd;
      w_cur_fault = w_fault;
      w_ram_addr  = bus.addr[AW+1:2];
      w_ram_mask  = bus.mask;
      w_ram_wdata = bus.write_data;
    end else begin
      w_cur_cmd   = r_cmd;
      w_cur_fault = r_fault;
    end
  end

  assign w_ram_en    = w_enter_resp && !w_cur_fault;
  assign w_ram_we    = (w_cur_cmd == CMD_WRITE);
  assign w_resp_data = r_rd_ok ? w_rdata : 32'h0000_0000;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_mask  (w_ram_mask),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)                             r_cnt <= CNT_LOAD;
      else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd   <= bus.cmd;
      r_fault <= w_fault;
      r_widx  <= bus.addr[AW+1:2];
      r_mask  <= bus.mask;
      r_wdata <= bus.write_data;
    end
  end

  // Response flags are fixed on the edge entering RESP; hold copies are taken while in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ok      <= 1'b0;
      r_resp_fault <= 1'b0;
      r_load_data  <= 32'h0000_0000;
      r_error      <= 1'b0;
    end else begin
      if (w_enter_resp) begin
        r_rd_ok      <= !w_cur_fault && (w_cur_cmd == CMD_READ);
        r_resp_fault <= w_cur_fault;
      end
      if (r_state == RESP) begin
        r_load_data <= w_resp_data;
        r_error     <= r_resp_fault;
      end
    end
  end

  always_comb begin
    bus.ready     = w_ready;
    bus.valid     = 1'b0;
    bus.load_data = 32'h0000_0000;
    bus.error     = 1'b0;
    if (rst) begin
      bus.valid     = 1'b0;
      bus.load_data = 32'h0000_0000;
      bus.error     = 1'b0;
    end else if (r_state == RESP) begin
      bus.valid     = 1'b1;
      bus.load_data = w_resp_data;
      bus.error     = r_resp_fault;
    end else begin
      bus.load_data = r_load_data;
      bus.error     = r_error;
    end
  end

endmodule
